// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, LSB first, oversampled by CLOCKS_PER_BIT.
// The line is synchronised first; a falling edge is confirmed at the middle of
// the start bit, and each data bit and the stop bit are then sampled one full
// bit period apart, so every sample lands near the middle of its bit.
// valid / framing_error are single-cycle pulses.
// Handshake: valid is a one-cycle, push-only strobe with no ready; databus is
// stable from the valid cycle until the next valid pulse.
module uart_receiver #(
    parameter int CLOCKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inserial,
    output logic [7:0] databus,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    // Last counter value in a bit period, and the half-bit point used to
    // confirm the start bit.
    localparam logic [7:0] LAST = 8'(CLOCKS_PER_BIT - 1);
    localparam logic [7:0] HALF = 8'((CLOCKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATABIT,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t     state;
    logic [7:0] count;
    logic [2:0] index;
    logic [7:0] shift;
    logic       rx_meta;
    logic       rx_s;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= inserial;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with registered outputs; the counter restarts on every
    // state change so each state measures time from its own entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= 8'd0;
            index         <= 3'd0;
            shift         <= 8'h00;
            databus       <= 8'h00;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            valid         <= 1'b0;
            framing_error <= 1'b0;
            case (state)
                IDLE: begin
                    count <= 8'd0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (count == HALF) begin
                        count <= 8'd0;
                        if (!rx_s) begin
                            state <= DATABIT;
                            index <= 3'd0;
                        end else begin
                            // Start bit did not last half a bit: a glitch.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                DATABIT: begin
                    if (count == LAST) begin
                        count        <= 8'd0;
                        shift[index] <= rx_s;
                        if (index == 3'd7) begin
                            state <= STOP;
                        end else begin
                            index <= index + 3'd1;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                STOP: begin
                    if (count == LAST) begin
                        count <= 8'd0;
                        if (rx_s) begin
                            databus <= shift;
                            valid   <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            // Bad stop bit: report it and wait out a held-low
                            // line so a break does not start a false frame.
                            framing_error <= 1'b1;
                            state         <= WAIT_IDLE;
                        end
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                WAIT_IDLE: begin
                    count <= 8'd0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 8'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frame table against a default-rate receiver, plus
// hand-written sequences for glitch, break, reset mid-frame and back-to-back
// frames on a CLOCKS_PER_BIT=16 receiver.
module tb_uart_receiver;

    localparam int CPB_A  = 217;
    localparam int HALF_A = (CPB_A - 1) / 2;
    localparam int CPB_B  = 16;
    localparam int PERIOD = 10;

    logic       clk;
    logic       rst_n;
    logic       rx_a;
    logic       rx_b;
    logic [7:0] databus_a;
    logic       valid_a;
    logic       ferr_a;
    logic       busy_a;
    logic [7:0] databus_b;
    logic       valid_b;
    logic       ferr_b;
    logic       busy_b;

    int checks = 0;
    int errors = 0;

    // Event counters from the monitors.
    int valid_cnt_a = 0;
    int ferr_cnt_a  = 0;
    int long_valid_a = 0;
    int both_a      = 0;
    logic prev_valid_a = 1'b0;
    time last_valid_time_a = 0;
    time fall_time = 0;
    int valid_cnt_b = 0;
    int ferr_cnt_b  = 0;
    int both_b      = 0;
    logic [7:0] exp_q[$];

    uart_receiver #(.CLOCKS_PER_BIT(CPB_A)) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .inserial     (rx_a),
        .databus      (databus_a),
        .valid        (valid_a),
        .framing_error(ferr_a),
        .busy         (busy_a)
    );

    uart_receiver #(.CLOCKS_PER_BIT(CPB_B)) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .inserial     (rx_b),
        .databus      (databus_b),
        .valid        (valid_b),
        .framing_error(ferr_b),
        .busy         (busy_b)
    );

    // Clock
    initial clk = 1'b0;
    always #(PERIOD / 2) clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one line for n clock periods starting at the current negedge.
    task automatic drive_line(input int which, input logic val, input int n);
        if (which == 0) rx_a = val;
        else            rx_b = val;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame at the sender's own bit period.
    task automatic send_frame(input int which, input logic [7:0] d, input int cpb,
                              input logic stop_val);
        fall_time = $time;
        drive_line(which, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_line(which, d[i], cpb);
        drive_line(which, stop_val, cpb);
        drive_line(which, 1'b1, 0);
    endtask

    // Monitor for the default-rate receiver.
    always @(negedge clk) begin
        if (valid_a) begin
            valid_cnt_a++;
            last_valid_time_a = $time;
        end
        if (ferr_a) ferr_cnt_a++;
        if (valid_a && prev_valid_a) long_valid_a++;
        if (valid_a && ferr_a) both_a++;
        prev_valid_a = valid_a;
    end

    // Scoreboard for the 16-clock receiver: every valid byte is popped in order.
    always @(negedge clk) begin
        if (valid_b) begin
            valid_cnt_b++;
            if (exp_q.size() == 0) begin
                check("b_unexpected_valid", 32'(databus_b), 32'h1ff);
            end else begin
                check("b_databus", 32'(databus_b), 32'(exp_q.pop_front()));
            end
        end
        if (ferr_b) ferr_cnt_b++;
        if (valid_b && ferr_b) both_b++;
    end

    typedef struct {
        logic [7:0] data;
        int         cpb;
        logic       stop_val;
        logic [7:0] exp_db;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int v0;
        int f0;
        int lat;
        int exp_lat;
        int polls;
        logic [7:0] last_good;
        logic [7:0] pat;

        vecs[0] = '{8'hA5, 217, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 217, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 217, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h55, 210, 1'b1, 8'h55, 1, 0};
        vecs[4] = '{8'hC3, 224, 1'b1, 8'hC3, 1, 0};
        vecs[5] = '{8'h96, 217, 1'b0, 8'hC3, 0, 1};
        vecs[6] = '{8'h01, 224, 1'b1, 8'h01, 1, 0};
        exp_lat = 2 + (HALF_A + 1) + 9 * CPB_A;

        // Reset
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_databus_a", 32'(databus_a), 32'h00);
        check("rst_valid_a", 32'(valid_a), 32'h0);
        check("rst_ferr_a", 32'(ferr_a), 32'h0);
        check("rst_busy_a", 32'(busy_a), 32'h0);
        check("rst_databus_b", 32'(databus_b), 32'h00);
        check("rst_busy_b", 32'(busy_b), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_busy_a", 32'(busy_a), 32'h0);

        // Frame table on the default-rate receiver
        for (int k = 0; k < 7; k++) begin
            v0 = valid_cnt_a;
            f0 = ferr_cnt_a;
            send_frame(0, vecs[k].data, vecs[k].cpb, vecs[k].stop_val);
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_databus", k), 32'(databus_a), 32'(vecs[k].exp_db));
            check($sformatf("vec%0d_valid_count", k), 32'(valid_cnt_a - v0), 32'(vecs[k].exp_valid));
            check($sformatf("vec%0d_ferr_count", k), 32'(ferr_cnt_a - f0), 32'(vecs[k].exp_ferr));
            check($sformatf("vec%0d_busy_after", k), 32'(busy_a), 32'h0);
            if (vecs[k].exp_valid == 1 && vecs[k].cpb == CPB_A) begin
                lat = int'((last_valid_time_a - fall_time) / PERIOD);
                checks++;
                if (lat < exp_lat - 1 || lat > exp_lat + 1) begin
                    errors++;
                    $display("FAIL vec%0d_latency actual=%0d expected=%0d+-1", k, lat, exp_lat);
                end
            end
        end
        last_good = 8'h01;

        // Start glitch: line low 50 cycles only
        v0 = valid_cnt_a;
        f0 = ferr_cnt_a;
        drive_line(0, 1'b0, 50);
        drive_line(0, 1'b1, 1);
        check("glitch_busy_started", 32'(busy_a), 32'h1);
        polls = 0;
        while (busy_a && polls < HALF_A + 3) begin
            @(negedge clk);
            polls++;
        end
        check("glitch_busy_returns_low", 32'(busy_a), 32'h0);
        repeat (20) @(negedge clk);
        check("glitch_no_valid", 32'(valid_cnt_a - v0), 32'h0);
        check("glitch_no_ferr", 32'(ferr_cnt_a - f0), 32'h0);

        // 0x3C with low stop bit, then the line held low 1000 more cycles
        v0 = valid_cnt_a;
        f0 = ferr_cnt_a;
        pat = 8'h3C;
        drive_line(0, 1'b0, CPB_A);
        for (int i = 0; i < 8; i++) drive_line(0, pat[i], CPB_A);
        drive_line(0, 1'b0, CPB_A + 1000);
        check("break_ferr_count", 32'(ferr_cnt_a - f0), 32'h1);
        check("break_no_valid", 32'(valid_cnt_a - v0), 32'h0);
        check("break_databus_kept", 32'(databus_a), 32'(last_good));
        check("break_busy_held", 32'(busy_a), 32'h1);
        drive_line(0, 1'b1, 5);
        check("break_busy_released", 32'(busy_a), 32'h0);
        repeat (300) @(negedge clk);
        check("break_no_retrigger", 32'(valid_cnt_a - v0), 32'h0);
        check("break_ferr_once", 32'(ferr_cnt_a - f0), 32'h1);

        // Reset during bit 4 of 0x5A, then a clean 0x12
        v0 = valid_cnt_a;
        f0 = ferr_cnt_a;
        pat = 8'h5A;
        drive_line(0, 1'b0, CPB_A);
        for (int i = 0; i < 4; i++) drive_line(0, pat[i], CPB_A);
        drive_line(0, pat[4], 100);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_a), 32'h0);
        check("midrst_databus", 32'(databus_a), 32'h00);
        check("midrst_valid", 32'(valid_a), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_line(0, 1'b1, 300);
        check("midrst_no_valid", 32'(valid_cnt_a - v0), 32'h0);
        check("midrst_no_ferr", 32'(ferr_cnt_a - f0), 32'h0);
        send_frame(0, 8'h12, CPB_A, 1'b1);
        repeat (20) @(negedge clk);
        check("after_rst_valid_count", 32'(valid_cnt_a - v0), 32'h1);
        check("after_rst_databus", 32'(databus_a), 32'h12);

        // Back-to-back frames on the 16-clock receiver, no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h81);
        send_frame(1, 8'h00, CPB_B, 1'b1);
        send_frame(1, 8'hFF, CPB_B, 1'b1);
        send_frame(1, 8'h81, CPB_B, 1'b1);
        repeat (40) @(negedge clk);
        check("b2b_valid_count", 32'(valid_cnt_b), 32'h3);
        check("b2b_queue_drained", 32'(exp_q.size()), 32'h0);
        check("b2b_no_ferr", 32'(ferr_cnt_b), 32'h0);
        check("b2b_busy_after", 32'(busy_b), 32'h0);

        // Pulse properties over the whole run
        check("valid_single_cycle_a", 32'(long_valid_a), 32'h0);
        check("valid_ferr_exclusive_a", 32'(both_a), 32'h0);
        check("valid_ferr_exclusive_b", 32'(both_b), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
